// File: rtl/demux_1to8_deser.sv
// Serial-to-parallel receiver for the 8:1 mux serializer. Each accepted bit fills lane sel, and a full word
// is published on out_a/out_b one cycle after the 8th bit. There is no backpressure, so the consumer must keep up.
module demux_1to8_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sof,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic       frame_valid,
    output logic       frame_abort,
    output logic [2:0] sel
);

    logic [2:0] sel_q, sel_d;
    logic [7:0] stg_q, stg_d;
    logic [3:0] out_a_q, out_a_d;
    logic [3:0] out_b_q, out_b_d;
    logic       fv_q, fv_d;
    logic       fa_q, fa_d;
    logic [7:0] word;

    always_comb begin
        sel_d   = sel_q;
        stg_d   = stg_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        fv_d    = 1'b0;
        fa_d    = 1'b0;
        word    = {din, stg_q[6:0]};
        if (din_valid) begin
            if (sof) begin
                // Stale upper bits are harmless: every lane is rewritten before the next publish.
                stg_d[0] = din;
                sel_d    = 3'd1;
                fa_d     = (sel_q != 3'd0);
            end else begin
                stg_d[sel_q] = din;
                sel_d        = sel_q + 3'd1;
                if (sel_q == 3'd7) begin
                    out_a_d = {word[6], word[4], word[2], word[0]};
                    out_b_d = {word[7], word[5], word[3], word[1]};
                    fv_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 3'd0;
            stg_q   <= 8'h00;
            out_a_q <= 4'h0;
            out_b_q <= 4'h0;
            fv_q    <= 1'b0;
            fa_q    <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            stg_q   <= stg_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
        end
    end

    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign frame_valid = fv_q;
    assign frame_abort = fa_q;
    assign sel         = sel_q;

endmodule

// File: tb/tb_demux_1to8_deser.sv
// Randomized and directed bench for demux_1to8_deser. The scoreboard model is kept as a queue of bits received
// since the start of the frame.
module tb_demux_1to8_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din, din_valid, sof;
    logic [3:0] out_a, out_b;
    logic       frame_valid, frame_abort;
    logic [2:0] sel;

    demux_1to8_deser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .out_a       (out_a),
        .out_b       (out_b),
        .frame_valid (frame_valid),
        .frame_abort (frame_abort),
        .sel         (sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       abort;
        bit [3:0] a;
        bit [3:0] b;
    } ev_t;

    ev_t      exp_q[$];
    bit       partial[$];
    bit [3:0] last_a, last_b;
    int       vectors = 0;
    int       miscompares = 0;
    int       cyc = 0;
    int       fv_cnt = 0;
    int       fa_cnt = 0;
    int       fv_stamps[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect bits since the frame start; eight bits make a word, d0 = LSB.
    task automatic model_accept(input bit d, input bit s);
        bit [7:0] w;
        ev_t      e;
        if (s) begin
            if (partial.size() != 0) begin
                e.abort = 1'b1; e.a = '0; e.b = '0;
                exp_q.push_back(e);
            end
            partial.delete();
        end
        partial.push_back(d);
        if (partial.size() == 8) begin
            w = '0;
            for (int i = 0; i < 8; i++) w[i] = partial[i];
            e.abort = 1'b0;
            for (int i = 0; i < 4; i++) begin
                e.a[i] = w[2*i];
                e.b[i] = w[2*i+1];
            end
            exp_q.push_back(e);
            partial.delete();
        end
    endtask

    task automatic model_reset();
        partial.delete();
        exp_q.delete();
        last_a = '0;
        last_b = '0;
    endtask

    task automatic drive(input bit v, input bit d, input bit s);
        din_valid = v; din = d; sof = s;
        @(posedge clk);
        if (v) model_accept(d, s);
        #1;
        din_valid = 1'b0; din = 1'b0; sof = 1'b0;
    endtask

    task automatic send_frame(input bit [7:0] w, input bit with_sof);
        for (int i = 0; i < 8; i++) drive(1'b1, w[i], with_sof && (i == 0));
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out_a", {4'h0, out_a}, 8'h00);
        chk("rst_out_b", {4'h0, out_b}, 8'h00);
        chk("rst_sel", {5'h0, sel}, 8'h00);
        chk("rst_pulses", {6'h0, frame_valid, frame_abort}, 8'h00);
        #4 rst_n = 1'b1;
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard whenever the DUT shows a pulse, checks held outputs otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid && frame_abort) chk("both_pulses", 8'h1, 8'h0);
            if (frame_valid || frame_abort) begin
                if (frame_valid) begin fv_cnt++; fv_stamps.push_back(cyc); end
                if (frame_abort) fa_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {6'h0, frame_valid, frame_abort}, 8'h00);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind", {6'h0, frame_valid, frame_abort}, e.abort ? 8'h01 : 8'h02);
                    if (!e.abort) begin
                        last_a = e.a;
                        last_b = e.b;
                    end
                end
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                chk("missing_pulse", 8'h00, 8'h01);
            end
            chk("out_a", {4'h0, out_a}, {4'h0, last_a});
            chk("out_b", {4'h0, out_b}, {4'h0, last_b});
            chk("sel", {5'h0, sel}, 8'(partial.size()));
        end
    end

    initial begin
        int fa0, fv0;
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
        model_reset();
        #12;
        chk("por_out_a", {4'h0, out_a}, 8'h00);
        chk("por_sel", {5'h0, sel}, 8'h00);
        #10 rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // Single frame d0..d7 = 1,0,1,1,0,0,1,0
        send_frame(8'b0100_1101, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("single_a", {4'h0, out_a}, 8'b1011);
        chk("single_b", {4'h0, out_b}, 8'b0010);
        chk("single_sel", {5'h0, sel}, 8'h00);

        // Same frame with 3-cycle gaps after bits 2 and 5
        fv0 = fv_cnt;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'b0100_1101 >> i, i == 0);
            if (i == 2 || i == 5) repeat (3) drive(1'b0, 1'b1, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_a", {4'h0, out_a}, 8'b1011);
        chk("gap_b", {4'h0, out_b}, 8'b0010);
        chk("gap_fv_count", 8'(fv_cnt - fv0), 8'd1);

        // Back-to-back frames, continuous valid
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("b2b_spacing", 8'(fv_stamps[$] - fv_stamps[$-1]), 8'd8);
        chk("b2b_a", {4'h0, out_a}, 8'b0110);
        chk("b2b_b", {4'h0, out_b}, 8'b0110);

        // Abort: 5 bits then a fresh all-ones frame
        fa0 = fa_cnt; fv0 = fv_cnt;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, i == 0);
        send_frame(8'hFF, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_count", 8'(fa_cnt - fa0), 8'd1);
        chk("abort_fv_count", 8'(fv_cnt - fv0), 8'd1);
        chk("abort_a", {4'h0, out_a}, 8'h0F);
        chk("abort_b", {4'h0, out_b}, 8'h0F);

        // Reset mid-frame, then 8'h01 without sof
        fa0 = fa_cnt;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, i == 0);
        async_reset();
        drive(1'b0, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("rstmid_abort", 8'(fa_cnt - fa0), 8'd0);
        chk("rstmid_a", {4'h0, out_a}, 8'b0001);
        chk("rstmid_b", {4'h0, out_b}, 8'b0000);

        // Random traffic: gaps, sof anywhere (including sel = 7), back-to-back frames
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        chk("drain_empty", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
